// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the control sequencer.
//   state_t        - sequencer FSM states (FETCH, EXEC)
//   CF_*           - bit positions of the decoder control word (ctrl_flags)
//   FLAG_*         - bit positions inside the ALU flag vector
//   COND_*         - branch condition codes carried in inst[9:8]
//   cond_hit()     - evaluates a condition code against the ALU flags
package ctrl_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    localparam int CF_LDI    = 0;
    localparam int CF_MEM_RE = 1;
    localparam int CF_MEM_WE = 2;
    localparam int CF_SPC    = 3;
    localparam int CF_WPC    = 4;
    localparam int CF_IPC    = 5;
    localparam int CF_ADI    = 6;
    localparam int CF_COND   = 7;
    localparam int CF_IMM3   = 8;
    localparam int CF_LUI    = 9;
    localparam int CF_SCR    = 10;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

    localparam logic [1:0] COND_Z  = 2'b00;
    localparam logic [1:0] COND_C  = 2'b01;
    localparam logic [1:0] COND_NZ = 2'b10;
    localparam logic [1:0] COND_NC = 2'b11;

    function automatic logic cond_hit(input logic [1:0] code, input logic [1:0] flags);
        logic hit;
        case (code)
            COND_Z:  hit = flags[FLAG_Z];
            COND_C:  hit = flags[FLAG_C];
            COND_NZ: hit = ~flags[FLAG_Z];
            default: hit = ~flags[FLAG_C];
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/scratch_regfile.sv
// scratch_regfile: SCR_N x XLEN scratch registers.
//   clk, rst_n  - clock and asynchronous active-low reset (clears all entries)
//   we          - write enable, write takes effect on the rising edge
//   waddr/wdata - write index and data
//   raddr/rdata - combinational read port; a same-cycle write is not visible
//                 until the following cycle, so a read of the index being
//                 written returns the old contents
module scratch_regfile #(
    parameter int XLEN  = 16,
    parameter int SCR_N = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] regs [SCR_N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SCR_N; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: two-state instruction sequencer.
//   FETCH reads the instruction at {pc,0} over the ready/valid memory port,
//   EXEC drives the datapath muxes, performs an optional load/store, updates
//   the PC on branches and writes the scratch register file.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flags[1:0]              ALU flags, [0]=Z, [1]=C
//   ctrl_flags[15:0]        decoder control word (bit map in ctrl_pkg)
//   reg_o0/reg_o1/reg_o2    register-file read data
//   alu_out                 ALU result
//   mem_out, mem_ready      memory read data and completion strobe
//   mem_req, mem_addr       memory request and byte address
//   mem_in, mem_we          store data and store strobe
//   mem_byte_half           access size, 1=half-word, 0=byte
//   inst                    latched instruction word
//   reg_in, reg_we          register-file write data and enable
//   alu_a, alu_b            ALU operands
module control_sequencer #(
    parameter int              XLEN     = 16,
    parameter int              SCR_N    = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      flags,
    input  logic [15:0]     ctrl_flags,
    input  logic [XLEN-1:0] reg_o0,
    input  logic [XLEN-1:0] reg_o1,
    input  logic [XLEN-1:0] reg_o2,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] mem_out,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_in,
    output logic            mem_we,
    output logic            mem_byte_half,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] reg_in,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic            reg_we
);

    import ctrl_pkg::*;

    localparam int              SCR_AW   = (SCR_N > 1) ? $clog2(SCR_N) : 1;
    localparam logic [XLEN-2:0] PC_RESET = RESET_PC[XLEN-1:1];
    localparam logic [XLEN-2:0] PC_ONE   = {{(XLEN-2){1'b0}}, 1'b1};

    state_t state, state_next;

    // Half-word program counter; the byte address is {pc,1'b0}.
    logic [XLEN-2:0] pc;
    logic [XLEN-1:0] pc_byte;

    logic f_ldi, f_mem_re, f_mem_we, f_spc, f_wpc, f_ipc;
    logic f_adi, f_cond, f_imm3, f_lui, f_scr;

    logic              mem_access;
    logic              fetch_done;
    logic              exec_done;
    logic              branch_taken;
    logic [SCR_AW-1:0] scr_idx;
    logic [XLEN-1:0]   scr_rdata;
    logic [XLEN-1:0]   lui_val;
    logic              unused_bits;

    assign f_ldi    = ctrl_flags[CF_LDI];
    assign f_mem_re = ctrl_flags[CF_MEM_RE];
    assign f_mem_we = ctrl_flags[CF_MEM_WE];
    assign f_spc    = ctrl_flags[CF_SPC];
    assign f_wpc    = ctrl_flags[CF_WPC];
    assign f_ipc    = ctrl_flags[CF_IPC];
    assign f_adi    = ctrl_flags[CF_ADI];
    assign f_cond   = ctrl_flags[CF_COND];
    assign f_imm3   = ctrl_flags[CF_IMM3];
    assign f_lui    = ctrl_flags[CF_LUI];
    assign f_scr    = ctrl_flags[CF_SCR];

    assign unused_bits = ^{ctrl_flags[15:11], inst[XLEN-1:10]};

    assign pc_byte      = {pc, 1'b0};
    assign scr_idx      = inst[SCR_AW-1:0];
    assign mem_access   = f_mem_re | f_mem_we;
    assign branch_taken = ~f_cond | cond_hit(inst[9:8], flags);
    assign mem_in       = reg_o0;

    scratch_regfile #(
        .XLEN  (XLEN),
        .SCR_N (SCR_N),
        .AW    (SCR_AW)
    ) u_scr (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (exec_done & f_scr),
        .waddr (scr_idx),
        .wdata (alu_out),
        .raddr (scr_idx),
        .rdata (scr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= PC_RESET;
            inst  <= '0;
        end else begin
            state <= state_next;
            if (fetch_done) begin
                inst <= mem_out;
                pc   <= pc + PC_ONE;
            end else if (exec_done && f_wpc && branch_taken) begin
                pc <= alu_out[XLEN-1:1];
            end
        end
    end

    // exec_done marks the last EXEC cycle: it qualifies the PC update, the
    // scratch write and the single reg_we pulse of the instruction. While
    // reset is asserted the request and strobes are forced low so a pending
    // memory transaction is dropped immediately rather than at the next edge.
    always_comb begin
        state_next    = state;
        mem_req       = 1'b0;
        mem_addr      = pc_byte;
        mem_byte_half = 1'b1;
        mem_we        = 1'b0;
        reg_we        = 1'b0;
        fetch_done    = 1'b0;
        exec_done     = 1'b0;
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    fetch_done = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (mem_access) begin
                    mem_req       = 1'b1;
                    mem_addr      = alu_out;
                    mem_byte_half = inst[3];
                    mem_we        = f_mem_we;
                    if (mem_ready) begin
                        exec_done  = 1'b1;
                        reg_we     = f_mem_re & ~f_mem_we;
                        state_next = FETCH;
                    end
                end else begin
                    exec_done  = 1'b1;
                    reg_we     = ~f_wpc | f_spc;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
        if (!rst_n) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            reg_we  = 1'b0;
        end
    end

    // lui forms a 16-bit value; anything above bit 15 stays zero.
    always_comb begin
        lui_val       = '0;
        lui_val[15:0] = {inst[7:0], reg_o0[7:0]};

        if (f_spc) begin
            reg_in = pc_byte;
        end else if (f_ldi) begin
            reg_in = {{(XLEN-8){inst[7]}}, inst[7:0]};
        end else if (f_mem_re) begin
            reg_in = mem_out;
        end else if (f_lui) begin
            reg_in = lui_val;
        end else begin
            reg_in = alu_out;
        end

        if (f_adi) begin
            alu_b = {{(XLEN-4){inst[3]}}, inst[3:0]};
        end else if (f_imm3) begin
            alu_b = {{(XLEN-3){1'b0}}, inst[2:0]};
        end else if (f_scr) begin
            alu_b = scr_rdata;
        end else if (f_ipc) begin
            alu_b = pc_byte;
        end else begin
            alu_b = reg_o2;
        end

        if (f_ipc) begin
            alu_a = {{(XLEN-9){inst[7]}}, inst[7:0], 1'b0};
        end else begin
            alu_a = reg_o1;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  flags;
    logic [15:0] ctrl_flags;
    logic [15:0] reg_o0, reg_o1, reg_o2, alu_out, mem_out;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_byte_half, reg_we;
    logic [15:0] mem_addr, mem_in, inst, reg_in, alu_a, alu_b;

    int testsRun;
    int testsFailed;

    logic [15:0] expRegQ[$];
    logic [15:0] expPc;
    logic [15:0] expInst;

    typedef struct {
        logic [15:0] instWord;
        logic [15:0] ctrl;
        logic [15:0] r0;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] alu;
        logic [15:0] expRegIn;
        logic [15:0] expAluA;
        logic [15:0] expAluB;
    } vec_t;

    vec_t vecs[10];

    control_sequencer #(
        .XLEN     (16),
        .SCR_N    (16),
        .RESET_PC (16'h0040)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flags         (flags),
        .ctrl_flags    (ctrl_flags),
        .reg_o0        (reg_o0),
        .reg_o1        (reg_o1),
        .reg_o2        (reg_o2),
        .alu_out       (alu_out),
        .mem_out       (mem_out),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_in        (mem_in),
        .mem_we        (mem_we),
        .mem_byte_half (mem_byte_half),
        .inst          (inst),
        .reg_in        (reg_in),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .reg_we        (reg_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Scoreboard: every reg_we pulse must match the oldest queued write.
    task automatic watchRegWrite();
        logic [15:0] e;
        if (reg_we === 1'b1) begin
            testsRun++;
            if (expRegQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL sb_unexpected_write: got reg_we=1 reg_in=%h, expected no write", reg_in);
            end else begin
                e = expRegQ.pop_front();
                if (reg_in !== e) begin
                    testsFailed++;
                    $display("[TB] FAIL sb_reg_in: got %h, expected %h", reg_in, e);
                end
            end
        end
    endtask

    task automatic sampleEdge();
        @(negedge clk);
        watchRegWrite();
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        ctrl_flags = v.ctrl;
        reg_o0     = v.r0;
        reg_o1     = v.r1;
        reg_o2     = v.r2;
        alu_out    = v.alu;
        flags      = 2'b00;
        mem_ready  = 1'b0;
    endtask

    task automatic fetchInst(input logic [15:0] word, input int waits);
        ctrl_flags = 16'h0000;
        flags      = 2'b00;
        mem_ready  = 1'b0;
        mem_out    = 16'hDEAD;
        for (int i = 0; i < waits; i++) begin
            sampleEdge();
            checkOutput("fetch_wait_req", {15'd0, mem_req}, 16'd1);
            checkOutput("fetch_wait_addr", mem_addr, expPc);
            checkOutput("fetch_wait_inst", inst, expInst);
            nextCycle();
        end
        mem_ready = 1'b1;
        mem_out   = word;
        sampleEdge();
        checkOutput("fetch_req", {15'd0, mem_req}, 16'd1);
        checkOutput("fetch_addr", mem_addr, expPc);
        checkOutput("fetch_byte_half", {15'd0, mem_byte_half}, 16'd1);
        checkOutput("fetch_mem_we", {15'd0, mem_we}, 16'd0);
        nextCycle();
        mem_ready = 1'b0;
        expInst   = word;
        expPc     = expPc + 16'd2;
    endtask

    // Single-cycle EXEC with optional alu_b expectation.
    task automatic execOne(input string tag, input logic [15:0] ctrl, input logic [1:0] fl,
                           input logic [15:0] aluOut, input logic expWe, input logic [15:0] expRegIn,
                           input logic chkB, input logic [15:0] expB);
        ctrl_flags = ctrl;
        flags      = fl;
        alu_out    = aluOut;
        mem_ready  = 1'b0;
        if (expWe) expRegQ.push_back(expRegIn);
        sampleEdge();
        checkOutput({tag, "_inst"}, inst, expInst);
        checkOutput({tag, "_reg_we"}, {15'd0, reg_we}, {15'd0, expWe});
        if (chkB) checkOutput({tag, "_alu_b"}, alu_b, expB);
        nextCycle();
        ctrl_flags = 16'h0000;
        flags      = 2'b00;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        flags       = 2'b00;
        ctrl_flags  = 16'h0000;
        reg_o0      = 16'h0000;
        reg_o1      = 16'h0000;
        reg_o2      = 16'h0000;
        alu_out     = 16'h0000;
        mem_out     = 16'h0000;
        mem_ready   = 1'b1;

        //            inst      ctrl      r0        r1        r2        alu       regIn     aluA      aluB
        vecs[0] = '{16'h0100, 16'h0000, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h3333, 16'h1111, 16'h2222};
        vecs[1] = '{16'h0080, 16'h0001, 16'h0000, 16'h0101, 16'h0202, 16'h0303, 16'hFF80, 16'h0101, 16'h0202};
        vecs[2] = '{16'h00AB, 16'h0200, 16'h12CD, 16'h0001, 16'h0002, 16'h0003, 16'hABCD, 16'h0001, 16'h0002};
        vecs[3] = '{16'h000E, 16'h0040, 16'h0000, 16'h0010, 16'h0020, 16'h0030, 16'h0030, 16'h0010, 16'hFFFE};
        vecs[4] = '{16'h000F, 16'h0100, 16'h0000, 16'h0011, 16'h0022, 16'h0044, 16'h0044, 16'h0011, 16'h0007};
        vecs[5] = '{16'h000D, 16'h0140, 16'h0000, 16'h0012, 16'h0023, 16'h0055, 16'h0055, 16'h0012, 16'hFFFD};
        vecs[6] = '{16'h0012, 16'h0201, 16'h0034, 16'h0013, 16'h0024, 16'h0066, 16'h0012, 16'h0013, 16'h0024};
        vecs[7] = '{16'h00FF, 16'h0060, 16'h0000, 16'h0014, 16'h0025, 16'h0077, 16'h0077, 16'hFFFE, 16'hFFFF};
        vecs[8] = '{16'h0040, 16'h0120, 16'h0000, 16'h0015, 16'h0026, 16'h0088, 16'h0088, 16'h0080, 16'h0000};
        vecs[9] = '{16'h0001, 16'h0200, 16'hFF7F, 16'h0016, 16'h0027, 16'h0099, 16'h017F, 16'h0016, 16'h0027};

        // Reset: request held off while rst_n is low
        repeat (2) @(posedge clk);
        sampleEdge();
        checkOutput("reset_mem_req", {15'd0, mem_req}, 16'd0);
        checkOutput("reset_inst", inst, 16'h0000);
        nextCycle();
        rst_n   = 1'b1;
        expPc   = 16'h0040;
        expInst = 16'h0000;

        // First fetch at RESET_PC; ipc exposes the incremented pc on alu_b
        fetchInst(16'h0000, 0);
        execOne("first_pc", 16'h0020, 2'b00, 16'h0777, 1'b1, 16'h0777, 1'b1, 16'h0042);

        // Table-driven operand and write-data muxing
        for (int i = 0; i < 10; i++) begin
            fetchInst(vecs[i].instWord, 0);
            applyStimulus(vecs[i]);
            expRegQ.push_back(vecs[i].expRegIn);
            sampleEdge();
            checkOutput($sformatf("vec%0d_reg_in", i), reg_in, vecs[i].expRegIn);
            checkOutput($sformatf("vec%0d_alu_a", i), alu_a, vecs[i].expAluA);
            checkOutput($sformatf("vec%0d_alu_b", i), alu_b, vecs[i].expAluB);
            checkOutput($sformatf("vec%0d_reg_we", i), {15'd0, reg_we}, 16'd1);
            nextCycle();
        end

        // Fetch stalled three cycles before completing
        fetchInst(16'h0300, 3);
        execOne("stall_exec", 16'h0000, 2'b00, 16'h0abc, 1'b1, 16'h0abc, 1'b0, 16'h0000);

        // Half-word load with two wait states
        fetchInst(16'h0008, 0);
        ctrl_flags = 16'h0002;
        alu_out    = 16'h1234;
        mem_out    = 16'hBEEF;
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b0;
            sampleEdge();
            checkOutput("load_wait_req", {15'd0, mem_req}, 16'd1);
            checkOutput("load_wait_addr", mem_addr, 16'h1234);
            checkOutput("load_wait_bh", {15'd0, mem_byte_half}, 16'd1);
            checkOutput("load_wait_reg_we", {15'd0, reg_we}, 16'd0);
            nextCycle();
        end
        mem_ready = 1'b1;
        expRegQ.push_back(16'hBEEF);
        sampleEdge();
        checkOutput("load_done_addr", mem_addr, 16'h1234);
        checkOutput("load_done_reg_we", {15'd0, reg_we}, 16'd1);
        nextCycle();
        mem_ready = 1'b0;

        // Byte store with mem_re also set: store wins, no register write
        fetchInst(16'h0000, 0);
        ctrl_flags = 16'h0006;
        alu_out    = 16'h0050;
        reg_o0     = 16'h9876;
        mem_ready  = 1'b1;
        sampleEdge();
        checkOutput("store_mem_we", {15'd0, mem_we}, 16'd1);
        checkOutput("store_addr", mem_addr, 16'h0050);
        checkOutput("store_data", mem_in, 16'h9876);
        checkOutput("store_bh", {15'd0, mem_byte_half}, 16'd0);
        checkOutput("store_reg_we", {15'd0, reg_we}, 16'd0);
        nextCycle();
        mem_ready = 1'b0;

        // Conditional branch on ~Z: not taken with Z=1, taken with Z=0
        fetchInst(16'h0200, 0);
        execOne("bnz_not_taken", 16'h0090, 2'b01, 16'h0200, 1'b0, 16'h0000, 1'b0, 16'h0000);
        fetchInst(16'h0200, 0);
        execOne("bnz_taken", 16'h0090, 2'b00, 16'h0200, 1'b0, 16'h0000, 1'b0, 16'h0000);
        expPc = 16'h0200;
        // Branch on C taken
        fetchInst(16'h0100, 0);
        execOne("bc_taken", 16'h0090, 2'b10, 16'h0300, 1'b0, 16'h0000, 1'b0, 16'h0000);
        expPc = 16'h0300;
        // Unconditional jump, target bit 0 dropped
        fetchInst(16'h0000, 0);
        execOne("jump_odd", 16'h0010, 2'b00, 16'h0401, 1'b0, 16'h0000, 1'b0, 16'h0000);
        expPc = 16'h0400;
        // Call: link register gets the incremented pc
        fetchInst(16'h0000, 0);
        execOne("call", 16'h0018, 2'b00, 16'h0100, 1'b1, 16'h0402, 1'b0, 16'h0000);
        expPc = 16'h0100;

        // Scratch registers: write SCR[7], read back, others still zero
        fetchInst(16'h0007, 0);
        execOne("scr7_write", 16'h0400, 2'b00, 16'hA5A5, 1'b1, 16'hA5A5, 1'b1, 16'h0000);
        fetchInst(16'h0007, 0);
        execOne("scr7_read", 16'h0400, 2'b00, 16'h5A5A, 1'b1, 16'h5A5A, 1'b1, 16'hA5A5);
        fetchInst(16'h0006, 0);
        execOne("scr6_read", 16'h0400, 2'b00, 16'h1111, 1'b1, 16'h1111, 1'b1, 16'h0000);
        fetchInst(16'h000F, 0);
        execOne("scr15_read", 16'h0400, 2'b00, 16'h2222, 1'b1, 16'h2222, 1'b1, 16'h0000);

        // Reset asserted during a store wait
        fetchInst(16'h0008, 0);
        ctrl_flags = 16'h0004;
        alu_out    = 16'h0060;
        mem_ready  = 1'b0;
        sampleEdge();
        checkOutput("rst_store_req", {15'd0, mem_req}, 16'd1);
        checkOutput("rst_store_we", {15'd0, mem_we}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_req", {15'd0, mem_req}, 16'd0);
        checkOutput("rst_async_we", {15'd0, mem_we}, 16'd0);
        nextCycle();
        nextCycle();
        rst_n      = 1'b1;
        ctrl_flags = 16'h0000;
        expPc      = 16'h0040;
        expInst    = 16'h0000;
        sampleEdge();
        checkOutput("post_rst_inst", inst, 16'h0000);
        nextCycle();
        fetchInst(16'h0007, 0);
        execOne("post_rst_scr7", 16'h0400, 2'b00, 16'h0001, 1'b1, 16'h0001, 1'b1, 16'h0000);

        checkOutput("scoreboard_drained", expRegQ.size()[15:0], 16'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
